// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants and state encoding for the 4x4 systolic sequencer
package systolic_pkg;

    // Array edge length; the array is always square 4x4
    localparam int N                    = 4;
    localparam int NE                   = N * N;

    // Default operand and accumulator widths
    localparam int DW_DEFAULT           = 8;
    localparam int RW_DEFAULT           = 16;

    // A full skewed wavefront of an NxN operand pair takes 2N-1 steps
    localparam int FEED_STEPS           = 2 * N - 1;

    // Zero-feed cycles so the last product reaches the far corner PE
    localparam int DRAIN_CYCLES_DEFAULT = N - 1;

    // Step counter width; shared by the feed and drain phases
    localparam int STEP_W               = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        CAPTURE
    } state_t;

endpackage

// File: rtl/systolic_ctrl_if.sv
// rtl/systolic_ctrl_if.sv - host and array-side signal bundle of the systolic sequencer
interface systolic_ctrl_if #(
    parameter int DW = 8,
    parameter int RW = 16
);

    // Host operand write port
    logic             wr_en;
    logic             wr_sel;
    logic [3:0]       wr_addr;
    logic [DW-1:0]    wr_data;

    // Host control and status
    logic             start;
    logic             busy;
    logic             done;
    logic [16*RW-1:0] c_out;

    // Array side
    logic             arr_clr;
    logic [4*DW-1:0]  a_feed;
    logic [4*DW-1:0]  b_feed;
    logic [16*RW-1:0] r_in;

    // Host plus array model: drives operands, start and accumulators
    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, r_in,
        input  busy, done, c_out, arr_clr, a_feed, b_feed
    );

    // Sequencer side
    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, r_in,
        output busy, done, c_out, arr_clr, a_feed, b_feed
    );

endinterface

// File: rtl/systolic_skew_mux.sv
// rtl/systolic_skew_mux.sv - combinational skewed wavefront selector for A rows and B columns
module systolic_skew_mux
    import systolic_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [STEP_W-1:0] step,
    input  logic [NE*DW-1:0]  mem_a,
    input  logic [NE*DW-1:0]  mem_b,
    output logic [N*DW-1:0]   a_lanes,
    output logic [N*DW-1:0]   b_lanes
);

    // Lane i is delayed by i steps: row i carries A[i][t-i], column i carries B[t-i][i], zero outside the band
    always_comb begin
        a_lanes = '0;
        b_lanes = '0;
        for (int i = 0; i < N; i++) begin
            if ((int'(step) >= i) && ((int'(step) - i) < N)) begin
                a_lanes[DW*i +: DW] = mem_a[DW*(i*N + (int'(step) - i)) +: DW];
                b_lanes[DW*i +: DW] = mem_b[DW*((int'(step) - i)*N + i) +: DW];
            end
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - sequencer that clears, feeds, drains and captures a 4x4 output-stationary array
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int DW           = DW_DEFAULT,
    parameter int RW           = RW_DEFAULT,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    systolic_ctrl_if.slave bus
);

    state_t                state_q,    state_d;
    logic [STEP_W-1:0]     step_q,     step_d;
    logic [NE*DW-1:0]      mem_a_q,    mem_a_d;
    logic [NE*DW-1:0]      mem_b_q,    mem_b_d;
    logic [N*DW-1:0]       a_feed_q,   a_feed_d;
    logic [N*DW-1:0]       b_feed_q,   b_feed_d;
    logic                  arr_clr_q,  arr_clr_d;
    logic                  done_q,     done_d;
    logic [NE*RW-1:0]      c_out_q,    c_out_d;

    logic [N*DW-1:0]       mux_a;
    logic [N*DW-1:0]       mux_b;

    // The mux looks at the step the array will see next cycle so the feed lanes can be registered
    systolic_skew_mux #(
        .DW (DW)
    ) u_skew_mux (
        .step    (step_d),
        .mem_a   (mem_a_q),
        .mem_b   (mem_b_q),
        .a_lanes (mux_a),
        .b_lanes (mux_b)
    );

    // Next-state and step counter; the counter is reused for feed steps and drain cycles
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLEAR;
                    step_d  = '0;
                end
            end
            CLEAR: begin
                state_d = FEED;
                step_d  = '0;
            end
            FEED: begin
                if (step_q == STEP_W'(FEED_STEPS - 1)) begin
                    state_d = DRAIN;
                    step_d  = '0;
                end else begin
                    step_d  = step_q + 1'b1;
                end
            end
            DRAIN: begin
                if (step_q == STEP_W'(DRAIN_CYCLES - 1)) begin
                    state_d = CAPTURE;
                    step_d  = '0;
                end else begin
                    step_d  = step_q + 1'b1;
                end
            end
            CAPTURE: begin
                state_d = IDLE;
                step_d  = '0;
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Operand storage, feeds, clear strobe, done pulse and result capture
    always_comb begin
        mem_a_d   = mem_a_q;
        mem_b_d   = mem_b_q;
        a_feed_d  = '0;
        b_feed_d  = '0;
        arr_clr_d = 1'b0;
        done_d    = 1'b0;
        c_out_d   = c_out_q;

        // Host writes only land while idle so a running multiply sees frozen operands
        if ((state_q == IDLE) && bus.wr_en) begin
            if (bus.wr_sel) begin
                mem_b_d[DW*bus.wr_addr +: DW] = bus.wr_data;
            end else begin
                mem_a_d[DW*bus.wr_addr +: DW] = bus.wr_data;
            end
        end

        if (state_d == FEED) begin
            a_feed_d = mux_a;
            b_feed_d = mux_b;
        end

        arr_clr_d = (state_d == CLEAR);

        if (state_q == CAPTURE) begin
            c_out_d = bus.r_in;
            done_d  = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            step_q    <= '0;
            mem_a_q   <= '0;
            mem_b_q   <= '0;
            a_feed_q  <= '0;
            b_feed_q  <= '0;
            arr_clr_q <= 1'b0;
            done_q    <= 1'b0;
            c_out_q   <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            mem_a_q   <= mem_a_d;
            mem_b_q   <= mem_b_d;
            a_feed_q  <= a_feed_d;
            b_feed_q  <= b_feed_d;
            arr_clr_q <= arr_clr_d;
            done_q    <= done_d;
            c_out_q   <= c_out_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.arr_clr = arr_clr_q;
    assign bus.a_feed  = a_feed_q;
    assign bus.b_feed  = b_feed_q;
    assign bus.c_out   = c_out_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - self-checking bench with array model and matrix-level reference
module tb_systolic_ctrl;

    localparam int DW = 8;
    localparam int RW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    systolic_ctrl_if #(.DW(DW), .RW(RW)) bus ();

    systolic_ctrl #(.DW(DW), .RW(RW), .DRAIN_CYCLES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cnt      = 0;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural 4x4 output-stationary array ----------------
    logic [DW-1:0] ar_a [4][4];
    logic [DW-1:0] ar_b [4][4];
    logic [RW-1:0] acc  [4][4];

    function automatic logic [DW-1:0] a_in(int i, int j);
        return (j == 0) ? bus.a_feed[DW*i +: DW] : ar_a[i][j-1];
    endfunction

    function automatic logic [DW-1:0] b_in(int i, int j);
        return (i == 0) ? bus.b_feed[DW*j +: DW] : ar_b[i-1][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (bus.arr_clr) begin
                    ar_a[i][j] <= '0;
                    ar_b[i][j] <= '0;
                    acc[i][j]  <= '0;
                end else begin
                    ar_a[i][j] <= a_in(i, j);
                    ar_b[i][j] <= b_in(i, j);
                    acc[i][j]  <= acc[i][j] + RW'(a_in(i, j)) * RW'(b_in(i, j));
                end
            end
        end
    end

    always_comb begin
        bus.r_in = '0;
        for (int k = 0; k < 16; k++) bus.r_in[RW*k +: RW] = acc[k/4][k%4];
    end

    // ---------------- matrix-level reference model ----------------
    int   m_cyc;
    logic m_done;
    int   mA [16];
    int   mB [16];
    int   m_c [16];

    function automatic int mm(int i, int j);
        int s = 0;
        for (int k = 0; k < 4; k++) s += mA[i*4+k] * mB[k*4+j];
        return s % 65536;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc  <= 0;
            m_done <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                mA[k]  <= 0;
                mB[k]  <= 0;
                m_c[k] <= 0;
            end
        end else begin
            m_done <= (m_cyc == 12);
            if (m_cyc == 12) begin
                m_cyc <= 0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) m_c[i*4+j] <= mm(i, j);
            end else if (m_cyc != 0) begin
                m_cyc <= m_cyc + 1;
            end else if (bus.start) begin
                m_cyc <= 1;
            end
            if ((m_cyc == 0) && bus.wr_en) begin
                if (bus.wr_sel) mB[bus.wr_addr] <= int'(bus.wr_data);
                else            mA[bus.wr_addr] <= int'(bus.wr_data);
            end
        end
    end

    function automatic logic [4*DW-1:0] exp_a();
        logic [4*DW-1:0] v = '0;
        if (m_cyc >= 2 && m_cyc <= 8)
            for (int i = 0; i < 4; i++)
                if (m_cyc - 2 - i >= 0 && m_cyc - 2 - i <= 3) v[DW*i +: DW] = DW'(mA[i*4 + (m_cyc-2-i)]);
        return v;
    endfunction

    function automatic logic [4*DW-1:0] exp_b();
        logic [4*DW-1:0] v = '0;
        if (m_cyc >= 2 && m_cyc <= 8)
            for (int j = 0; j < 4; j++)
                if (m_cyc - 2 - j >= 0 && m_cyc - 2 - j <= 3) v[DW*j +: DW] = DW'(mB[(m_cyc-2-j)*4 + j]);
        return v;
    endfunction

    function automatic logic [16*RW-1:0] exp_c();
        logic [16*RW-1:0] v = '0;
        for (int k = 0; k < 16; k++) v[RW*k +: RW] = RW'(m_c[k]);
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy",    bus.busy,    m_cyc != 0);
            chk("done",    bus.done,    m_done);
            chk("arr_clr", bus.arr_clr, m_cyc == 1);
            chk("a_feed",  bus.a_feed,  exp_a());
            chk("b_feed",  bus.b_feed,  exp_b());
            chk("c_out",   bus.c_out,   exp_c());
        end
    end

    // ---------------- stimulus ----------------
    int ta [16];
    int tbm [16];
    int rec_a [40];
    int rec_b [40];
    int lat;
    int s0;

    task automatic wr(input logic sel, input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = 4'(addr);
        bus.wr_data = DW'(data);
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic load();
        for (int k = 0; k < 16; k++) wr(1'b0, k, ta[k]);
        for (int k = 0; k < 16; k++) wr(1'b1, k, tbm[k]);
    endtask

    task automatic run();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        s0  = cnt - 1;
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            rec_a[cnt - s0] = int'(bus.a_feed[DW*2 +: DW]);
            rec_b[cnt - s0] = int'(bus.b_feed[DW*3 +: DW]);
            if (bus.done) begin
                lat = cnt - s0;
                break;
            end
            @(negedge clk);
        end
        chk("done_latency", lat, 13);
        @(negedge clk);
    endtask

    function automatic logic [255:0] all16(int v);
        logic [255:0] r = '0;
        for (int k = 0; k < 16; k++) r[RW*k +: RW] = RW'(v);
        return r;
    endfunction

    logic [255:0] lit;
    int seq_a [7];
    int seq_b [7];
    int ndone;
    int dcyc [$];

    initial begin
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 1'b0;

        // reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy",    bus.busy,    0);
        chk("rst_done",    bus.done,    0);
        chk("rst_arr_clr", bus.arr_clr, 0);
        chk("rst_a_feed",  bus.a_feed,  0);
        chk("rst_b_feed",  bus.b_feed,  0);
        chk("rst_c_out",   bus.c_out,   0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // identity
        for (int k = 0; k < 16; k++) begin
            ta[k]  = (k / 4 == k % 4) ? 1 : 0;
            tbm[k] = k + 1;
        end
        load();
        run();
        for (int k = 0; k < 16; k++) lit[RW*k +: RW] = RW'(k + 1);
        chk("identity_c", bus.c_out, lit);

        // busy protection: write and start during FEED are ignored
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        s0 = cnt - 1;
        while (cnt - s0 < 4) @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 8'd9; bus.start = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        chk("busy_single_done", ndone, 1);
        chk("busy_c_unchanged", bus.c_out, lit);
        wr(1'b0, 0, 9);
        run();
        for (int j = 0; j < 4; j++) lit[RW*j +: RW] = RW'(9 * (j + 1));
        chk("busy_next_uses_9", bus.c_out, lit);

        // all ones, then all 255 (wraps mod 2^16)
        for (int k = 0; k < 16; k++) begin ta[k] = 1; tbm[k] = 1; end
        load();
        run();
        chk("ones_c", bus.c_out, all16(4));
        for (int k = 0; k < 16; k++) begin ta[k] = 255; tbm[k] = 255; end
        load();
        run();
        chk("max_c", bus.c_out, all16(63492));

        // skew
        for (int k = 0; k < 16; k++) begin ta[k] = k / 4 + 1; tbm[k] = 1; end
        load();
        run();
        seq_a = '{0, 0, 3, 3, 3, 3, 0};
        seq_b = '{0, 0, 0, 1, 1, 1, 1};
        for (int t = 0; t < 7; t++) begin
            chk("skew_a_row2", rec_a[t + 2], seq_a[t]);
            chk("skew_b_col3", rec_b[t + 2], seq_b[t]);
        end
        for (int k = 0; k < 16; k++) lit[RW*k +: RW] = RW'(4 * (k / 4 + 1));
        chk("skew_c", bus.c_out, lit);

        // randomized operands
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 16; k++) begin
                ta[k]  = int'($urandom_range(0, 255));
                tbm[k] = int'($urandom_range(0, 255));
            end
            load();
            run();
        end

        // reset mid-operation
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        s0 = cnt - 1;
        while (cnt - s0 < 5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",    bus.busy,    0);
        chk("mid_rst_done",    bus.done,    0);
        chk("mid_rst_arr_clr", bus.arr_clr, 0);
        chk("mid_rst_a_feed",  bus.a_feed,  0);
        chk("mid_rst_b_feed",  bus.b_feed,  0);
        chk("mid_rst_c_out",   bus.c_out,   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            ta[k]  = int'($urandom_range(0, 255));
            tbm[k] = int'($urandom_range(0, 255));
        end
        load();
        run();

        // back-to-back with start held high: each run restarts in the previous done cycle
        bus.start = 1'b1;
        @(negedge clk);
        s0 = cnt - 1;
        for (int c = 0; c < 45; c++) begin
            if (bus.done) dcyc.push_back(cnt - s0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("b2b_count", dcyc.size() >= 3, 1);
        if (dcyc.size() >= 3) begin
            chk("b2b_done1", dcyc[0], 13);
            chk("b2b_done2", dcyc[1], 26);
            chk("b2b_done3", dcyc[2], 39);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
